// File: rtl/conv_pe_sr.sv
// Streaming KxK convolution PE: serial kernel load, line-buffer window over a
// row-major pixel stream, one registered multiply-accumulate per valid window.
module conv_pe_sr #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned ROW_W = 32,
  parameter int unsigned K     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     weight_in,
  output logic [2*WIDTH-1:0]   data_out
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned KK     = K * K;
  localparam int unsigned SR_LEN = (K - 1) * ROW_W + K;
  localparam int unsigned CW     = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int unsigned RW     = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned WCW    = $clog2(KK + 1);

  logic [WIDTH-1:0] r_sr [SR_LEN];
  logic [WIDTH-1:0] r_w  [KK];
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [WCW-1:0]   r_wcnt;
  logic             r_win_vld;

  logic [PW-1:0]    w_prod [KK];
  logic [PW-1:0]    w_sum;
  logic             w_col_last;
  logic             w_win_now;

  assign w_col_last = (r_col == CW'(ROW_W - 1));
  assign w_win_now  = (r_row == RW'(K - 1)) && (r_col >= CW'(K - 1));

  // Line buffer: r_sr[0] is the newest pixel, r_sr[k] is the pixel k samples ago.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SR_LEN); k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= data_in;
      for (int k = 1; k < int'(SR_LEN); k++) r_sr[k] <= r_sr[k-1];
    end
  end

  // Kernel capture for the first KK samples, then held until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(KK); k++) r_w[k] <= '0;
      r_wcnt <= '0;
    end else if (r_wcnt < WCW'(KK)) begin
      for (int k = 0; k < int'(KK); k++) begin
        if (r_wcnt == WCW'(k)) r_w[k] <= weight_in;
      end
      r_wcnt <= r_wcnt + WCW'(1);
    end
  end

  // Column wraps every row; row count saturates once K rows are buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win_vld <= 1'b0;
    end else begin
      r_win_vld <= w_win_now;
      r_col     <= w_col_last ? '0 : r_col + CW'(1);
      if (w_col_last && (r_row != RW'(K - 1))) r_row <= r_row + RW'(1);
    end
  end

  // Window element x[i][j] sits (K-1-i) rows and (K-1-j) columns behind the newest pixel.
  always_comb begin
    for (int i = 0; i < int'(K); i++) begin
      for (int j = 0; j < int'(K); j++) begin
        w_prod[i*K+j] = PW'(r_w[i*K+j]) * PW'(r_sr[(K-1-i)*ROW_W + (K-1-j)]);
      end
    end
  end

  // Modulo-2^PW accumulation of the KK products.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(KK); k++) w_sum = w_sum + w_prod[k];
  end

  // Result register updates only for windows completed on the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n)         data_out <= '0;
    else if (r_win_vld) data_out <= w_sum;
  end

endmodule

// File: tb/tb_conv_pe_sr.sv
// Directed bench for conv_pe_sr: hand-computed checkpoints plus a per-cycle
// window model built from the image array and kernel.
module tb_conv_pe_sr;

  localparam int WIDTH = 9;
  localparam int ROW_W = 32;
  localparam int PW    = 2 * WIDTH;
  localparam int NIMG  = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] weight_in = '0;
  logic [PW-1:0]    data_out;

  logic [WIDTH-1:0] img [NIMG];
  logic [WIDTH-1:0] wts [9];
  logic [PW-1:0]    exp_out;

  int n_vec = 0;
  int n_err = 0;

  conv_pe_sr #(.WIDTH(WIDTH), .ROW_W(ROW_W), .K(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .weight_in (weight_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [WIDTH-1:0] pix, input logic [WIDTH-1:0] wt);
    data_in   = pix;
    weight_in = wt;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < cycles; k++) step(WIDTH'($urandom), WIDTH'($urandom));
    rst_n = 1'b1;
  endtask

  function automatic bit win_valid(input int n);
    return ((n % ROW_W) >= 2) && ((n / ROW_W) >= 2);
  endfunction

  function automatic logic [PW-1:0] win_model(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(wts[3*i+j]) * int'(img[n - (2-i)*ROW_W - (2-j)]);
    return PW'(acc);
  endfunction

  function automatic logic [WIDTH-1:0] wt_at(input int n);
    return (n < 9) ? wts[n] : WIDTH'($urandom);
  endfunction

  task automatic test_reset();
    hold_reset(3);
    n_vec++;
    if (data_out !== '0) begin
      n_err++;
      $display("FAIL reset_value: data_out=%0d expected=0", data_out);
    end
    for (int k = 0; k < 9; k++) wts[k] = WIDTH'($urandom);
    for (int n = 0; n <= 2*ROW_W + 2; n++) begin
      step(WIDTH'($urandom), wt_at(n));
      n_vec++;
      if (data_out !== '0) begin
        n_err++;
        $display("FAIL reset_quiet n=%0d: data_out=%0d expected=0", n, data_out);
      end
    end
  endtask

  task automatic test_all_ones();
    hold_reset(1);
    for (int k = 0; k < 9; k++) wts[k] = 1;
    exp_out = '0;
    for (int n = 0; n < 5*ROW_W + 4; n++) begin
      step(1, wt_at(n));
      if (n >= 67) exp_out = 9;
      n_vec++;
      if (data_out !== exp_out) begin
        n_err++;
        $display("FAIL all_ones n=%0d: data_out=%0d expected=%0d", n, data_out, exp_out);
      end
    end
  endtask

  task automatic test_mixed();
    logic [WIDTH-1:0] kw [9];
    kw = '{1, 2, 3, 2, 3, 4, 3, 4, 5};
    for (int k = 0; k < 9; k++) wts[k] = kw[k];
    for (int n = 0; n < NIMG; n++) img[n] = WIDTH'((n * 37 + 11) % 512);
    img[0] = 2;        img[1] = 1;         img[2] = 1;
    img[ROW_W] = 1;    img[ROW_W+1] = 1;   img[ROW_W+2] = 2;
    img[2*ROW_W] = 1;  img[2*ROW_W+1] = 2; img[2*ROW_W+2] = 2;
    hold_reset(1);
    exp_out = '0;
    for (int n = 0; n < 4*ROW_W + 8; n++) begin
      step(img[n], wt_at(n));
      if (n == 67) begin
        n_vec++;
        if (data_out !== PW'(41)) begin
          n_err++;
          $display("FAIL mixed_first: data_out=%0d expected=41", data_out);
        end
      end
      if (n >= 1 && win_valid(n-1)) exp_out = win_model(n-1);
      n_vec++;
      if (data_out !== exp_out) begin
        n_err++;
        $display("FAIL mixed_model n=%0d: data_out=%0d expected=%0d", n, data_out, exp_out);
      end
    end
  endtask

  task automatic test_center_ramp();
    for (int k = 0; k < 9; k++) wts[k] = (k == 4) ? 1 : 0;
    hold_reset(1);
    exp_out = '0;
    for (int n = 0; n < 5*ROW_W + 6; n++) begin
      step(WIDTH'(n % 512), wt_at(n));
      if (n >= 1 && win_valid(n-1)) exp_out = PW'((n - 1 - ROW_W - 1) % 512);
      n_vec++;
      if (data_out !== exp_out) begin
        n_err++;
        $display("FAIL center_ramp n=%0d: data_out=%0d expected=%0d", n, data_out, exp_out);
      end
    end
  endtask

  task automatic test_truncation();
    for (int k = 0; k < 9; k++) wts[k] = 511;
    hold_reset(1);
    exp_out = '0;
    for (int n = 0; n < 3*ROW_W + 6; n++) begin
      step(511, wt_at(n));
      if (n >= 67) exp_out = PW'(252937);
      n_vec++;
      if (data_out !== exp_out) begin
        n_err++;
        $display("FAIL truncation n=%0d: data_out=%0d expected=%0d", n, data_out, exp_out);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 9; k++) wts[k] = WIDTH'($urandom_range(1, 511));
    for (int n = 0; n < NIMG; n++) img[n] = WIDTH'($urandom_range(1, 511));
    hold_reset(1);
    for (int n = 0; n < 3*ROW_W + 10; n++) step(img[n], wt_at(n));
    n_vec++;
    if (data_out !== win_model(3*ROW_W + 8)) begin
      n_err++;
      $display("FAIL pre_reset: data_out=%0d expected=%0d", data_out, win_model(3*ROW_W + 8));
    end
    hold_reset(1);
    n_vec++;
    if (data_out !== '0) begin
      n_err++;
      $display("FAIL mid_reset_value: data_out=%0d expected=0", data_out);
    end
    for (int k = 0; k < 9; k++) wts[k] = WIDTH'(k);
    for (int n = 0; n < NIMG; n++) img[n] = WIDTH'((n * 13 + 5) % 512);
    exp_out = '0;
    for (int n = 0; n < 4*ROW_W + 4; n++) begin
      step(img[n], wt_at(n));
      if (n >= 1 && win_valid(n-1)) exp_out = win_model(n-1);
      n_vec++;
      if (data_out !== exp_out) begin
        n_err++;
        $display("FAIL mid_reset_restart n=%0d: data_out=%0d expected=%0d", n, data_out, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_mixed();
    test_center_ramp();
    test_truncation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
